// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: expands a 512-bit block into W[0..63], one word per cycle, W[0] one cycle after start.
// hold freezes every register while running; SHA256_KCONST_EN adds the aligned round constant output k_out.
module sha256_msg_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic         hold,
    output logic         busy,
    output logic         w_valid,
    output logic [31:0]  w_out,
    output logic [5:0]   round_idx,
`ifdef SHA256_KCONST_EN
    output logic [31:0]  k_out,
`endif
    output logic         done
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t            r_state;
    // r_win[j] holds W[t+j] while W[t] is presented; r_win[15] is refilled from the recurrence.
    logic [15:0][31:0] r_win;
    logic [31:0]       w_new;
    logic [5:0]        w_idx_nxt;

`ifdef SHA256_KCONST_EN
    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
`endif

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign w_new     = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];
    assign w_idx_nxt = round_idx + 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            w_valid   <= 1'b0;
            done      <= 1'b0;
            w_out     <= '0;
            round_idx <= '0;
            r_win     <= '0;
`ifdef SHA256_KCONST_EN
            k_out     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_RUN;
                        busy      <= 1'b1;
                        w_valid   <= 1'b1;
                        done      <= 1'b0;
                        w_out     <= block_in[511:480];
                        round_idx <= '0;
                        for (int k = 0; k < 16; k++) begin
                            r_win[k] <= block_in[511 - 32*k -: 32];
                        end
`ifdef SHA256_KCONST_EN
                        k_out     <= K_TAB[0];
`endif
                    end
                end
                S_RUN: begin
                    if (!hold) begin
                        if (round_idx == 6'd63) begin
                            // Last word leaves; w_out/round_idx keep their final values while idle.
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                            w_valid <= 1'b0;
                            done    <= 1'b0;
                        end else begin
                            w_out     <= r_win[1];
                            round_idx <= w_idx_nxt;
                            done      <= (w_idx_nxt == 6'd63);
                            for (int k = 0; k < 15; k++) begin
                                r_win[k] <= r_win[k+1];
                            end
                            r_win[15] <= w_new;
`ifdef SHA256_KCONST_EN
                            k_out     <= K_TAB[w_idx_nxt];
`endif
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
